// File: rtl/sevenseg_env_display.sv
// Eight-digit multiplexed seven-segment readout for temperature and humidity.
// Each value is converted to BCD by a sequential double-dabble engine before it is displayed.
module sevenseg_env_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] temp_in,
    input  logic [15:0] hum_in,
    output logic        busy,
    output logic [6:0]  seg,
    output logic [7:0]  an
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_H     = 7'b0001001;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t      state;
    logic [2:0]  iter;
    logic [19:0] t_sr, h_sr;          // {bcd[11:0], bin[7:0]}
    logic        t_ovf, h_ovf;
    logic        pend, p_tovf, p_hovf;
    logic [7:0]  p_t, p_h;
    logic [11:0] d_t, d_h;
    logic        d_tdash, d_hdash;
    logic [CW-1:0] rcnt;
    logic [2:0]  didx;

    logic        start_req, use_inputs, capture_pend;
    logic [7:0]  s_t, s_h;
    logic        s_tovf, s_hovf;
    logic [6:0]  seg_next;

    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] a;
        a = v;
        if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
        if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
        if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
        return {a[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] digit_pat(input logic [3:0] n);
        case (n)
            4'd0: digit_pat = 7'b1000000;
            4'd1: digit_pat = 7'b1111001;
            4'd2: digit_pat = 7'b0100100;
            4'd3: digit_pat = 7'b0110000;
            4'd4: digit_pat = 7'b0011001;
            4'd5: digit_pat = 7'b0010010;
            4'd6: digit_pat = 7'b0000010;
            4'd7: digit_pat = 7'b1111000;
            4'd8: digit_pat = 7'b0000000;
            4'd9: digit_pat = 7'b0010000;
            default: digit_pat = SEG_DASH;
        endcase
    endfunction

    // pos 0 = units, 1 = tens, 2 = hundreds; leading zeros are blanked.
    function automatic logic [6:0] num_seg(input logic [11:0] bcd, input logic dash,
                                           input logic [1:0] pos);
        if (dash) return SEG_DASH;
        case (pos)
            2'd0: return digit_pat(bcd[3:0]);
            2'd1: return (bcd[11:4] == 8'd0) ? SEG_BLANK : digit_pat(bcd[7:4]);
            2'd2: return (bcd[11:8] == 4'd0) ? SEG_BLANK : digit_pat(bcd[11:8]);
            default: return SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        start_req    = 1'b0;
        use_inputs   = 1'b0;
        capture_pend = load && (state != IDLE);
        case (state)
            IDLE: begin
                start_req  = load | pend;
                use_inputs = load;
            end
            COMMIT:  start_req = pend;
            default: start_req = 1'b0;
        endcase
        s_t    = use_inputs ? temp_in[7:0] : p_t;
        s_h    = use_inputs ? hum_in[7:0]  : p_h;
        s_tovf = use_inputs ? (temp_in[15:8] != 8'd0) : p_tovf;
        s_hovf = use_inputs ? (hum_in[15:8]  != 8'd0) : p_hovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            iter    <= 3'd0;
            t_sr    <= 20'd0;
            h_sr    <= 20'd0;
            t_ovf   <= 1'b0;
            h_ovf   <= 1'b0;
            pend    <= 1'b0;
            p_t     <= 8'd0;
            p_h     <= 8'd0;
            p_tovf  <= 1'b0;
            p_hovf  <= 1'b0;
            d_t     <= 12'd0;
            d_h     <= 12'd0;
            d_tdash <= 1'b1;
            d_hdash <= 1'b1;
        end else begin
            if (capture_pend) begin
                p_t    <= temp_in[7:0];
                p_h    <= hum_in[7:0];
                p_tovf <= temp_in[15:8] != 8'd0;
                p_hovf <= hum_in[15:8] != 8'd0;
                pend   <= 1'b1;
            end else if (start_req) begin
                pend <= 1'b0;
            end
            case (state)
                SHIFT: begin
                    t_sr <= dd_step(t_sr);
                    h_sr <= dd_step(h_sr);
                    iter <= iter + 3'd1;
                    if (iter == 3'd7) state <= COMMIT;
                end
                COMMIT: begin
                    d_t     <= t_sr[19:8];
                    d_h     <= h_sr[19:8];
                    d_tdash <= t_ovf;
                    d_hdash <= h_ovf;
                    state   <= IDLE;
                    busy    <= 1'b0;
                end
                default: ;
            endcase
            // Placed after the case so a restart out of COMMIT overrides its IDLE/busy update.
            if (start_req) begin
                t_sr  <= {12'd0, s_t};
                h_sr  <= {12'd0, s_h};
                t_ovf <= s_tovf;
                h_ovf <= s_hovf;
                iter  <= 3'd0;
                state <= SHIFT;
                busy  <= 1'b1;
            end
        end
    end

    always_comb begin
        case (didx)
            3'd0:                seg_next = SEG_C;
            3'd4:                seg_next = SEG_H;
            3'd1, 3'd2, 3'd3:    seg_next = num_seg(d_t, d_tdash, 2'(didx - 3'd1));
            default:             seg_next = num_seg(d_h, d_hdash, 2'(didx - 3'd5));
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt <= '0;
            didx <= 3'd0;
            an   <= 8'hFF;
            seg  <= 7'h7F;
        end else begin
            if (rcnt == CW'(REFRESH_DIV - 1)) begin
                rcnt <= '0;
                didx <= didx + 3'd1;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
            an  <= ~(8'b1 << didx);
            seg <= seg_next;
        end
    end
endmodule

// File: tb/tb_sevenseg_env_display.sv
// Randomised and directed bench for sevenseg_env_display.
// Expected digits are computed arithmetically from the decimal value, then compared against the scanned output.
module tb_sevenseg_env_display;
    localparam int RD = 4;

    logic        clk = 0;
    logic        rst = 1;
    logic        load = 0;
    logic [15:0] temp_in = 0;
    logic [15:0] hum_in = 0;
    logic        busy;
    logic [6:0]  seg;
    logic [7:0]  an;

    int vectors = 0;
    int miscompares = 0;

    // Reference display contents
    int exp_tv = 0, exp_hv = 0;
    bit exp_td = 1, exp_hd = 1;
    logic [6:0] exp_q[$];

    sevenseg_env_display #(.REFRESH_DIV(RD)) dut (
        .clk(clk), .rst(rst), .load(load), .temp_in(temp_in), .hum_in(hum_in),
        .busy(busy), .seg(seg), .an(an)
    );

    always #10 clk = ~clk;

    function automatic logic [6:0] pat(int n);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return tbl[n];
    endfunction

    function automatic logic [6:0] num_glyph(int v, bit dash, int pos);
        int h, t, u;
        if (dash) return 7'b0111111;
        h = v / 100; t = (v / 10) % 10; u = v % 10;
        if (pos == 0) return pat(u);
        if (pos == 1) return (h == 0 && t == 0) ? 7'b1111111 : pat(t);
        return (h == 0) ? 7'b1111111 : pat(h);
    endfunction

    function automatic logic [6:0] model_seg(int d);
        if (d == 0) return 7'b1000110;
        if (d == 4) return 7'b0001001;
        if (d < 4) return num_glyph(exp_tv, exp_td, d - 1);
        return num_glyph(exp_hv, exp_hd, d - 5);
    endfunction

    function automatic int an_digit(logic [7:0] a);
        for (int i = 0; i < 8; i++) if (a == ~(8'b1 << i)) return i;
        return -1;
    endfunction

    task automatic model_commit(logic [15:0] t, logic [15:0] h);
        exp_td = (t[15:8] != 0); exp_tv = t[7:0];
        exp_hd = (h[15:8] != 0); exp_hv = h[7:0];
    endtask

    task automatic check_frame(string name);
        int guard = 0;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        while (an == 8'hFE && guard < 40) begin @(negedge clk); guard++; end
        while (an != 8'hFE && guard < 80) begin @(negedge clk); guard++; end
        vectors++;
        if (an !== 8'hFE) begin
            miscompares++;
            $display("FAIL %s frame_sync: an=%h required FE", name, an);
            return;
        end
        for (int d = 0; d < 8; d++) exp_q.push_back(model_seg(d));
        for (int d = 0; d < 8; d++) begin
            exp_seg = exp_q.pop_front();
            exp_an = ~(8'b1 << d);
            vectors++;
            if (an !== exp_an || seg !== exp_seg) begin
                miscompares++;
                $display("FAIL %s digit%0d: an=%h seg=%b required an=%h seg=%b",
                         name, d, an, seg, exp_an, exp_seg);
            end
            repeat (RD) @(negedge clk);
        end
    endtask

    task automatic drive_load(logic [15:0] t, logic [15:0] h);
        load = 1; temp_in = t; hum_in = h;
    endtask

    task automatic test_reset();
        rst = 1;
        drive_load(16'd99, 16'd99);
        repeat (3) @(negedge clk);
        vectors++;
        if (an !== 8'hFF || seg !== 7'h7F || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: an=%h seg=%h busy=%b required FF 7F 0", an, seg, busy);
        end
        load = 0; rst = 0;
        @(negedge clk);
        vectors++;
        if (an !== 8'hFE || seg !== 7'b1000110 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_first: an=%h seg=%b busy=%b required FE 1000110 0", an, seg, busy);
        end
        check_frame("reset_dashes");
    endtask

    task automatic test_conv(string name, logic [15:0] t, logic [15:0] h);
        int high = 0;
        drive_load(t, h);
        @(negedge clk);
        load = 0;
        while (busy === 1'b1 && high < 20) begin high++; @(negedge clk); end
        vectors++;
        if (high != 9) begin
            miscompares++;
            $display("FAIL %s busy_len: %0d cycles required 9", name, high);
        end
        model_commit(t, h);
        check_frame(name);
    endtask

    task automatic test_back_to_back();
        int first_low = -1;
        int d;
        drive_load(16'd10, 16'd20);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 1) drive_load(16'd30, 16'd40);
            else if (k == 2) drive_load(16'd50, 16'd60);
            else load = 0;
            if (busy !== 1'b1 && first_low < 0) first_low = k;
            if (k == 9) model_commit(16'd10, 16'd20);
            if (k >= 10 && k <= 18) begin
                d = an_digit(an);
                vectors++;
                if (d < 0 || seg !== model_seg(d)) begin
                    miscompares++;
                    $display("FAIL b2b_first_commit k=%0d: an=%h seg=%b required seg=%b",
                             k, an, seg, (d < 0) ? 7'bx : model_seg(d));
                end
            end
        end
        vectors++;
        if (first_low != 18) begin
            miscompares++;
            $display("FAIL b2b_busy_len: %0d cycles required 18", first_low);
        end
        model_commit(16'd50, 16'd60);
        check_frame("b2b_final");
    endtask

    task automatic test_commit_edge_load();
        bit exp_b;
        drive_load(16'd1, 16'd2);
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (k == 8) drive_load(16'd3, 16'd4); else load = 0;
            exp_b = (k <= 8) || (k >= 10 && k <= 18);
            vectors++;
            if (busy !== exp_b) begin
                miscompares++;
                $display("FAIL commit_edge_busy k=%0d: busy=%b required %b", k, busy, exp_b);
            end
        end
        model_commit(16'd3, 16'd4);
        check_frame("commit_edge");
    endtask

    task automatic test_reset_mid();
        drive_load(16'd77, 16'd88);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            load = 0;
            if (k == 3) rst = 1;
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || an !== 8'hFF || seg !== 7'h7F) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b an=%h seg=%h required 0 FF 7F", busy, an, seg);
        end
        rst = 0;
        exp_td = 1; exp_hd = 1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid_idle k=%0d: busy=%b required 0", k, busy);
            end
        end
        check_frame("reset_mid_dashes");
    endtask

    task automatic test_random();
        logic [15:0] t, h;
        for (int i = 0; i < 6; i++) begin
            t = 16'($urandom_range(0, 255));
            h = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) t[15:8] = 8'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) h[15:8] = 8'($urandom_range(1, 255));
            test_conv($sformatf("random%0d", i), t, h);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_conv("t23_h45", 16'd23, 16'd45);
        test_conv("t0_h100", 16'd0, 16'd100);
        test_conv("ovf_h255", 16'h0123, 16'd255);
        test_back_to_back();
        test_commit_edge_load();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sevenseg_env_display.md
# sevenseg_env_display

Multiplexed 8-digit seven-segment driver for the tamagotchi environment readout. Sits directly downstream of the DHT11 reader: takes the binary temperature and humidity words it produces, converts each to BCD with a sequential double-dabble engine, and time-multiplexes the result, with unit glyphs, onto the board's common-anode display.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit; 1 ms at 50 MHz.
- `clk`  in  1: system clock, 50 MHz.
- `rst`  in  1: reset. One clock; reset is synchronous and active-high.
- `load`  in  1: one-cycle strobe. Samples `temp_in` and `hum_in` and starts a conversion.
- `temp_in`  in  16: binary temperature in °C. Bits [7:0] are converted.
- `hum_in`  in  16: binary relative humidity in %. Bits [7:0] are converted.
- `busy`  out  1: high while a conversion is in progress.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, active-low.
- `an`  out  8: digit enables, active-low. `an[0]` is the rightmost digit.

## Operation
- **Digit map:**
  - `an[0]` shows glyph C, pattern 1000110.
  - `an[3:1]` show temperature, hundreds/tens/units, with `an[1]` the units digit.
  - `an[4]` shows glyph H, pattern 0001001.
  - `an[7:5]` show humidity, with `an[5]` the units digit.
- **Digit patterns, 0–9:** 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- **Special patterns:** blank is 1111111; dash is 0111111.
- **Leading-zero blanking:**
  - Hundreds digit is blank when 0.
  - Tens digit is blank when both hundreds and tens are 0.
  - Units digit is always shown.
- **Overflow:** a value with bits [15:8] ≠ 0 shows dash on all three of its digits. The other value is unaffected.
- **Conversion FSM:**
  - IDLE → SHIFT on `load`. On that edge, latch both inputs, clear both 12-bit BCD accumulators and the iteration counter, and set the overflow flags.
  - SHIFT runs 8 iterations, one per cycle, on both values in parallel. Each iteration adds 3 to every BCD nibble ≥ 5, then shifts {bcd, bin} left by 1. After the 8th iteration, go to COMMIT.
  - COMMIT copies the BCD results and overflow flags into the display registers together. Next state is IDLE, or SHIFT if a load is pending.
- **Pending load:**
  - A `load` while busy latches the inputs into a one-deep pending buffer. A later `load` overwrites that buffer.
  - The in-flight conversion is never disturbed.
  - COMMIT then starts the pending conversion and clears the pending flag.
- **Scan:**
  - The refresh counter counts 0..REFRESH_DIV−1. On wrap, the digit index advances 0→7→0.
  - `an` and `seg` are registered from the digit index and the display registers.
  - Exactly one `an` bit is low at any time after reset.
- **Display registers before the first COMMIT:** all numeric digits show dash; the glyphs show normally.

## Timing
- **Reset values:**
  - `an`=8'hFF, `seg`=7'h7F, `busy`=0.
  - FSM=IDLE, digit index 0, refresh counter 0, pending flag 0.
  - Display registers hold "no data", shown as dashes.
- **First cycle after `rst` falls:** `an`=8'hFE, `seg`=1000110.
- **Conversion latency, with `load` sampled at edge N:**
  - `busy`=1 after edge N.
  - Shifts occur at edges N+1..N+8.
  - COMMIT is at edge N+9; `busy`=0 after N+9 unless a pending load restarts it.
  - The new value reaches `seg` at the first scan of that digit after N+9.
- **`load` with `rst` high:** ignored; reset wins.
- **Reset mid-conversion:** the conversion is aborted, the pending load is dropped, and the display returns to dashes.
- **`load` at the COMMIT edge itself:** treated as pending; the next conversion starts at N+10.
- **Digit period:** exactly REFRESH_DIV cycles per digit; full frame is 8×REFRESH_DIV.

## Test plan
- Reset with REFRESH_DIV=4, no load → `an` steps FE, FD, FB, … every 4 cycles. `seg` shows C, dash, dash, dash, H, dash, dash, dash.
- `load` with `temp_in`=23, `hum_in`=45 → `busy` high for exactly 9 cycles. Digits show blank,2,3,C and blank,4,5,H.
- `temp_in`=0, `hum_in`=100 → temperature shows blank,blank,0; humidity shows 1,0,0.
- `temp_in`=16'h0123 (overflow), `hum_in`=255 → temperature shows dash,dash,dash; humidity shows 2,5,5.
- `load` (10,20), then (30,40) and (50,60) while busy → first commit shows 10/20. A second conversion starts immediately and commits 50/60; 30/40 never appears.
- `rst` asserted 4 cycles into a conversion → `busy`=0, `an`=FF on the next edge, then dashes resume and no commit occurs.
